// File: rtl/leading_digit_normalizer_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// leading_digit_normalizer_pkg : shared constants, lz width, flags
// Rev 1.0
// ------------------------------------------------------------------
package leading_digit_normalizer_pkg;

  localparam int DIGIT_W = 4;

  function automatic int lz_width(input int digits);
    int w;
    w = 0;
    while ((1 << w) < digits) w++;
    return (w < 1) ? 1 : w;
  endfunction

  typedef struct packed {
    logic zero;
    logic clamped;
  } result_flags_t;

endpackage

`default_nettype wire

// File: rtl/leading_digit_normalizer_dec_lzd.sv
`default_nettype none
// ------------------------------------------------------------------
// dec_lzd : combinational count of leading all-zero BCD digits
// Rev 1.0
// ------------------------------------------------------------------
module dec_lzd
  import leading_digit_normalizer_pkg::*;
#(
  parameter int DIGITS = 7,
  parameter int LZW    = 3
) (
  input  logic [DIGIT_W*DIGITS-1:0] m,
  output logic [LZW-1:0]            lz,
  output logic                      zero
);

  // Ascending scan: the last nonzero digit seen is the most significant one.
  always_comb begin
    lz   = '0;
    zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (m[DIGIT_W*i +: DIGIT_W] != '0) begin
        lz   = LZW'(DIGITS - 1 - i);
        zero = 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/leading_digit_normalizer.sv
`default_nettype none
// ------------------------------------------------------------------
// leading_digit_normalizer : two-stage BCD mantissa/exponent normaliser
// Rev 1.0
// ------------------------------------------------------------------
module leading_digit_normalizer
  import leading_digit_normalizer_pkg::*;
#(
  parameter int DIGITS = 7,
  parameter int EW     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [EW-1:0]             e1,
  input  logic [EW-1:0]             e2,
  input  logic [DIGIT_W*DIGITS-1:0] m1,
  input  logic [DIGIT_W*DIGITS-1:0] m2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EW-1:0]             e1_out,
  output logic [EW-1:0]             e2_out,
  output logic [DIGIT_W*DIGITS-1:0] m1_out,
  output logic [DIGIT_W*DIGITS-1:0] m2_out,
  output logic                      m1_zero,
  output logic                      m2_zero,
  output logic                      e1_clamped,
  output logic                      e2_clamped
);

  localparam int MW  = DIGIT_W * DIGITS;
  localparam int LZW = lz_width(DIGITS);
  localparam int CW  = ((LZW > EW) ? LZW : EW) + 1;

  logic [MW-1:0]  w_m_in   [2];
  logic [EW-1:0]  w_e_in   [2];
  logic [LZW-1:0] w_lz     [2];
  logic           w_zero   [2];
  logic [MW-1:0]  w_m_norm [2];
  logic [EW-1:0]  w_e_norm [2];
  result_flags_t  w_flags  [2];

  logic           r1_valid;
  logic [MW-1:0]  r1_m     [2];
  logic [EW-1:0]  r1_e     [2];
  logic [LZW-1:0] r1_lz    [2];
  logic           r1_zero  [2];

  logic           r2_valid;
  logic [MW-1:0]  r2_m     [2];
  logic [EW-1:0]  r2_e     [2];
  result_flags_t  r2_flags [2];

  logic w_load1;
  logic w_load2;

  assign w_m_in[0] = m1;
  assign w_m_in[1] = m2;
  assign w_e_in[0] = e1;
  assign w_e_in[1] = e2;

  assign w_load2  = !r2_valid || out_ready;
  assign w_load1  = !r1_valid || w_load2;
  assign in_ready = w_load1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_operand
    logic [CW-1:0] w_e_ext;
    logic [CW-1:0] w_lz_ext;
    logic [CW-1:0] w_sh_ext;
    logic          w_clamped;

    dec_lzd #(
      .DIGITS (DIGITS),
      .LZW    (LZW)
    ) u_lzd (
      .m    (w_m_in[gi]),
      .lz   (w_lz[gi]),
      .zero (w_zero[gi])
    );

    // The shift can never exceed e, so the exponent subtraction cannot wrap.
    always_comb begin
      w_e_ext   = CW'(r1_e[gi]);
      w_lz_ext  = CW'(r1_lz[gi]);
      w_clamped = !r1_zero[gi] && (w_lz_ext > w_e_ext);
      w_sh_ext  = w_clamped ? w_e_ext : w_lz_ext;
    end

    assign w_m_norm[gi]        = r1_m[gi] << {w_sh_ext, 2'b00};
    assign w_e_norm[gi]        = EW'(w_e_ext - w_sh_ext);
    assign w_flags[gi].zero    = r1_zero[gi];
    assign w_flags[gi].clamped = w_clamped;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r1_m[i]    <= '0;
        r1_e[i]    <= '0;
        r1_lz[i]   <= '0;
        r1_zero[i] <= 1'b0;
      end
    end else if (w_load1) begin
      r1_valid <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < 2; i++) begin
          r1_m[i]    <= w_m_in[i];
          r1_e[i]    <= w_e_in[i];
          r1_lz[i]   <= w_lz[i];
          r1_zero[i] <= w_zero[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_valid <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r2_m[i]     <= '0;
        r2_e[i]     <= '0;
        r2_flags[i] <= '0;
      end
    end else if (w_load2) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        for (int i = 0; i < 2; i++) begin
          r2_m[i]     <= w_m_norm[i];
          r2_e[i]     <= w_e_norm[i];
          r2_flags[i] <= w_flags[i];
        end
      end
    end
  end

  assign out_valid  = r2_valid;
  assign m1_out     = r2_m[0];
  assign m2_out     = r2_m[1];
  assign e1_out     = r2_e[0];
  assign e2_out     = r2_e[1];
  assign m1_zero    = r2_flags[0].zero;
  assign m2_zero    = r2_flags[1].zero;
  assign e1_clamped = r2_flags[0].clamped;
  assign e2_clamped = r2_flags[1].clamped;

endmodule

`default_nettype wire

// File: doc/leading_digit_normalizer.md
LEADING_DIGIT_NORMALIZER -- requirements
Module: leading_digit_normalizer

Interface
REQ-001 The block SHALL have parameter DIGITS, default 7: number of 4-bit BCD digits per mantissa (legal range 2..32).
REQ-002 The block SHALL have parameter EW, default 8: exponent width in bits.
REQ-003 The block SHALL use one clock and an asynchronous active-low reset, with ports exactly as follows:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
REQ-004 The block SHALL have the following input ports:
- in_valid  input  1  input operand pair valid
- in_ready  output  1  block can accept an input pair this cycle
- e1, e2  input  EW  unsigned operand exponents
- m1, m2  input  4*DIGITS  BCD mantissas, most significant digit in the top nibble
REQ-005 The block SHALL have the following output ports:
- out_valid  output  1  result pair valid
- out_ready  input  1  downstream accepts the result
- e1_out, e2_out  output  EW  normalised exponents
- m1_out, m2_out  output  4*DIGITS  normalised mantissas
- m1_zero, m2_zero  output  1  mantissa was all-zero
- e1_clamped, e2_clamped  output  1  shift limited by exponent

Function
REQ-006 Per operand, the block SHALL compute lz = count of leading all-zero nibbles, range 0..DIGITS-1 for a nonzero mantissa.
REQ-007 Per operand, the block SHALL compute the shift amount as sh = min(lz, e), and SHALL produce m_out = m << (4*sh), zero-filled from the right, and e_out = e - sh (no underflow possible).
REQ-008 The block SHALL assert e_clamped exactly when lz > e.
REQ-009 For an all-zero mantissa, the block SHALL output m_out = 0 and e_out = e, with m_zero = 1 and e_clamped = 0.
REQ-010 The two operands SHALL be processed independently and in the same transaction.
REQ-011 The block SHALL be a two-stage pipeline:
- stage 1 registers the inputs together with lz1, lz2 and the zero flags
- stage 2 registers the clamped, shifted results
REQ-012 Latency SHALL be 2 cycles from an in_valid&&in_ready edge to out_valid, with out_ready held high.
REQ-013 Throughput SHALL be 1 pair per cycle when out_ready is held high.
REQ-014 A transfer SHALL occur on a rising clk edge where valid&&ready is high, at both the input and output sides.
REQ-015 Stage 2 SHALL load when !v2 || out_ready; stage 1 SHALL load when !v1 || (stage 2 loads).
REQ-016 in_ready SHALL equal the stage-1 load condition, and SHALL be combinational from out_ready.
REQ-017 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-018 With the pipeline full and out_ready low, in_ready SHALL be 0 and no input SHALL be lost or duplicated.
REQ-019 Order SHALL be preserved: results leave in acceptance order.
REQ-020 Simultaneous input and output transfers in the same cycle SHALL both complete, with no bubble inserted.
REQ-021 in_valid SHALL be ignored while in_ready = 0.
REQ-022 Data registers SHALL load only when their stage loads with valid data.

Reset
REQ-023 While rst_n = 0, all valid bits SHALL clear immediately and out_valid SHALL be 0.
REQ-024 While rst_n = 0, all data outputs and flags SHALL be 0.
REQ-025 Transactions in flight at reset assertion SHALL be discarded, with no output after release.
REQ-026 in_ready SHALL be 1 on the first cycle after release if out_ready is 1 or the pipeline is empty.

Structure
REQ-027 A shared package SHALL hold:
- the constant DIGIT_W = 4
- a function computing the ceil-log2 width of lz from DIGITS
- the result-flag struct {zero, clamped}
REQ-028 The block SHALL contain one sub-module, dec_lzd, a parametrised combinational leading-zero-digit counter, instantiated once per operand.

Verification
REQ-029 Bench scenario (defaults): m1=0x0001234, e1=10 -> m1_out=0x1234000, e1_out=7, flags 0, out_valid exactly 2 cycles later.
REQ-030 Bench scenario (clamp): m2=0x0000056, e2=2 -> m2_out=0x0005600, e2_out=0, e2_clamped=1.
REQ-031 Bench scenario (zero): m1=0x0000000, e1=5 -> m1_out=0, e1_out=5, m1_zero=1, e1_clamped=0. Also m1=0x9000000, e1=0 -> unchanged, flags 0.
REQ-032 Bench scenario (backpressure): hold out_ready=0 while streaming 4 pairs -> 2 accepted, then in_ready=0, outputs held; on release all 4 results emerge in order with none lost or duplicated.
REQ-033 Bench scenario (reset mid-stream): assert rst_n=0 with 2 pairs in flight -> out_valid=0 at once; after release no stale result appears.
REQ-034 Bench scenario (DIGITS=16, EW=10): m=0x0000000000000ABC, e=1000 -> m_out=0xABC0000000000000, e_out=987.
